dm_arbiter: RTL

- Two-requester arbiter for the single-port SISC data memory (dm).
- The CPU datapath (ld/st path driven by ctrl) and a debug/loader port share dm's address, write-data and write-enable.
- Round-robin grant, one access per grant, registered read-data return.
- Produces cpu_stall, which ctrl uses to hold pc_write and ir_load while the CPU waits for memory.

---
 rtl/sisc_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 28 ++
 rtl/dm_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared encodings and default widths for the SISC data-memory arbiter.
package sisc_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CPU  = 2'b01,
    DBG  = 2'b10
  } arb_state_e;

  // Owner value doubles as the bit index into the {dbg, cpu} request vector.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  function automatic arb_state_e owner_state(input owner_e o);
    return (o == OWN_DBG) ? DBG : CPU;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: chooses among non-excluded requesters,
// breaking a tie in favour of whoever did not own memory last.
module rr_pick2
  import sisc_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] exclude,
  input  owner_e     last_owner,
  output logic       pick_valid,
  output owner_e     pick
);

  logic [1:0] elig;

  assign elig = req & ~exclude;

  always_comb begin
    pick_valid = |elig;
    pick       = OWN_CPU;
    case (elig)
      2'b01:   pick = OWN_CPU;
      2'b10:   pick = OWN_DBG;
      2'b11:   pick = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
      default: pick = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// ld/st path and the debug/loader port; one access per grant, registered read return.
//
// Handshake: a requester holds req (with we/addr/wdata) until it sees its gnt;
// the access completes at the rising edge where req && gnt, and a read returns
// data with a one-cycle rvalid pulse on the following cycle.
module dm_arbiter
  import sisc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rdata
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  owner_e            last_owner_q;
  logic [1:0]        req_vec;
  logic [1:0]        excl_vec;
  logic              pick_valid;
  owner_e            pick;
  logic              own_req;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              cpu_rd_xfer;
  logic              dbg_rd_xfer;

  assign req_vec = {dbg_req, cpu_req};

  // The current owner always finishes at this edge (even if it dropped req),
  // so it is kept out of the pick and the other side gets the next slot.
  assign excl_vec = {state_q == DBG, state_q == CPU};

  rr_pick2 u_pick (
    .req        (req_vec),
    .exclude    (excl_vec),
    .last_owner (last_owner_q),
    .pick_valid (pick_valid),
    .pick       (pick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = IDLE;
    if (pick_valid) begin
      state_d = owner_state(pick);
    end
  end

  // Output decode and owner mux
  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (state_q)
      CPU: begin
        cpu_gnt   = 1'b1;
        own_req   = cpu_req;
        own_we    = cpu_we;
        own_addr  = cpu_addr;
        own_wdata = cpu_wdata;
      end
      DBG: begin
        dbg_gnt   = 1'b1;
        own_req   = dbg_req;
        own_we    = dbg_we;
        own_addr  = dbg_addr;
        own_wdata = dbg_wdata;
      end
      default: begin
        own_req = 1'b0;
      end
    endcase
  end

  assign dm_addr   = own_addr;
  assign dm_wdata  = own_wdata;
  assign dm_we     = own_we && own_req;
  assign cpu_stall = cpu_req && !cpu_gnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      last_owner_q <= OWN_DBG;
    end else if (state_q == CPU) begin
      last_owner_q <= OWN_CPU;
    end else if (state_q == DBG) begin
      last_owner_q <= OWN_DBG;
    end
  end

  assign cpu_rd_xfer = cpu_gnt && cpu_req && !cpu_we;
  assign dbg_rd_xfer = dbg_gnt && dbg_req && !dbg_we;

  // Read data is held between reads so a stalled CPU can sample it late.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_rd_xfer;
      if (cpu_rd_xfer) begin
        cpu_rdata <= dm_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_rd_xfer;
      if (dbg_rd_xfer) begin
        dbg_rdata <= dm_rdata;
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_f)
    !(cpu_gnt && dbg_gnt));
  a_state_legal: assert property (@(posedge clk) disable iff (!rst_f)
    state_q inside {IDLE, CPU, DBG});
  a_we_owned: assert property (@(posedge clk) disable iff (!rst_f)
    dm_we |-> (cpu_gnt || dbg_gnt));
  a_rvalid_excl: assert property (@(posedge clk) disable iff (!rst_f)
    !(cpu_rvalid && dbg_rvalid));
  a_cpu_no_repeat: assert property (@(posedge clk) disable iff (!rst_f)
    cpu_gnt |=> !cpu_gnt);
  a_dbg_no_repeat: assert property (@(posedge clk) disable iff (!rst_f)
    dbg_gnt |=> !dbg_gnt);

endmodule
